aoc3_line_feeder: RTL

- Upstream stage of the day-3 digit-selection stack.
- Accepts a raw ASCII byte stream, one line of digits at a time, and buffers the whole line so its length is known.
- Replays the line one digit per cycle as binary values, with a per-digit count of digits remaining, which the stack needs for its pop decisions.
- Emits a one-cycle line_start pulse before each replay, used as the stack's per-line clear.

---
 rtl/aoc3_line_feeder_pkg.sv | 26 ++
 rtl/aoc3_line_feeder_if.sv | 35 +++
 rtl/aoc3_line_buf.sv | 26 ++
 rtl/aoc3_line_feeder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/aoc3_line_feeder_pkg.sv
// Shared definitions for the day-3 digit-selection stack: ASCII codes,
// the line feeder state encoding and the downstream stack capacity.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package aoc3_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    localparam int STACK_CAP = 12;

    typedef enum logic [1:0] {
        FILL,
        START,
        REPLAY
    } feeder_state_t;

    function automatic logic is_ascii_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/aoc3_line_feeder_if.sv
// Byte-in / digit-out bundle between the upstream byte source, the line
// feeder and the digit-selection stack.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface aoc3_line_feeder_if;

    logic                   char_in_valid;
    logic [7:0]             char_in;
    logic                   char_in_ready;
    logic                   eof;
    logic                   line_start;
    logic                   digit_valid;
    logic [`DATA_WIDTH-1:0] digit_out;
    logic [`DATA_WIDTH-1:0] nums_left;
    logic                   line_end;
    logic                   busy;
    logic                   overflow;

    // Byte source and digit consumer side.
    modport master (
        output char_in_valid, char_in, eof,
        input  char_in_ready, line_start, digit_valid, digit_out,
               nums_left, line_end, busy, overflow
    );

    // Line feeder side.
    modport slave (
        input  char_in_valid, char_in, eof,
        output char_in_ready, line_start, digit_valid, digit_out,
               nums_left, line_end, busy, overflow
    );

endinterface

// File: rtl/aoc3_line_buf.sv
// Line buffer: MAX_LINE x 4-bit register file, one synchronous write port,
// one combinational read port. Contents are not reset.
module aoc3_line_buf #(
    parameter int MAX_LINE = 128,
    parameter int ADDR_W   = $clog2(MAX_LINE)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [3:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [3:0]        rdata_o
);

    logic [3:0] mem_q [MAX_LINE];

    // Store one digit per accepted write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/aoc3_line_feeder.sv
// Line feeder: buffers one ASCII line of digits, then replays it one digit
// per cycle with the count of digits remaining, preceded by a line_start pulse.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module aoc3_line_feeder
    import aoc3_pkg::*;
#(
    parameter int MAX_LINE = 128,
    parameter int LEN_W    = $clog2(MAX_LINE) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    aoc3_line_feeder_if.slave    bus
);

    localparam int              ADDR_W  = $clog2(MAX_LINE);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_LINE);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    feeder_state_t    state_q, state_d;
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             overflow_q, overflow_d;

    logic             buf_we;
    logic [3:0]       buf_rdata;
    logic [LEN_W-1:0] left;
    logic             ready, line_start, digit_valid, line_end;

    logic             byte_digit, byte_lf, buf_full;

    assign byte_digit = is_ascii_digit(bus.char_in);
    assign byte_lf    = (bus.char_in == ASCII_LF);
    assign buf_full   = (wr_ptr_q == MAX_LEN);

    // Low nibble of '0'..'9' is the digit value, so no subtraction is needed.
    aoc3_line_buf #(
        .MAX_LINE (MAX_LINE),
        .ADDR_W   (ADDR_W)
    ) u_line_buf (
        .clk_i   (clock),
        .we_i    (buf_we),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (bus.char_in[3:0]),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (buf_rdata)
    );

    // Next-state and output decode for the fill / start / replay sequence.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        overflow_d  = overflow_q;
        buf_we      = 1'b0;
        ready       = 1'b0;
        line_start  = 1'b0;
        digit_valid = 1'b0;
        line_end    = 1'b0;
        left        = '0;
        case (state_q)
            FILL: begin
                ready = 1'b1;
                if (bus.char_in_valid && byte_digit) begin
                    if (buf_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        buf_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE;
                    end
                end
                // eof and a newline together still close only one line.
                if (((bus.char_in_valid && byte_lf) || bus.eof) && (wr_ptr_d != '0)) begin
                    len_d   = wr_ptr_d;
                    state_d = START;
                end
            end
            START: begin
                line_start = 1'b1;
                rd_ptr_d   = '0;
                state_d    = REPLAY;
            end
            REPLAY: begin
                digit_valid = 1'b1;
                left        = len_q - rd_ptr_q;
                rd_ptr_d    = rd_ptr_q + ONE;
                if (rd_ptr_q == len_q - ONE) begin
                    line_end = 1'b1;
                    wr_ptr_d = '0;
                    state_d  = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Control registers; overflow is sticky until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            len_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.char_in_ready = ready;
    assign bus.line_start    = line_start;
    assign bus.digit_valid   = digit_valid;
    assign bus.digit_out     = digit_valid ? {{(`DATA_WIDTH-4){1'b0}}, buf_rdata} : '0;
    assign bus.nums_left     = {{(`DATA_WIDTH-LEN_W){1'b0}}, left};
    assign bus.line_end      = line_end;
    assign bus.busy          = (state_q != FILL);
    assign bus.overflow      = overflow_q;

endmodule
